// File: rtl/div_pkg.sv
// div_pkg: shared op encodings, FSM states and step count for the RV32M divider
package div_pkg;
  localparam logic [1:0] DIV_OP  = 2'b00;
  localparam logic [1:0] DIVU_OP = 2'b01;
  localparam logic [1:0] REM_OP  = 2'b10;
  localparam logic [1:0] REMU_OP = 2'b11;
  localparam int DIV_STEPS = 32;
  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
endpackage

// File: rtl/div_unit.sv
// div_unit: iterative restoring RV32M divider (DIV/DIVU/REM/REMU) with start/busy/done handshake
module div_unit
  import div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  div_state_t state, state_n;
  logic [$clog2(DIV_STEPS)-1:0] cnt;
  logic is_rem, neg_q, neg_r;
  logic [XLEN:0] rem, sh, r_n;
  logic [XLEN-1:0] quo, dvs, q_n, a1, a2, spec_res, fin;
  logic sgn, dz, ovf, accept, last, ge;
  always_comb begin
    sgn = ~op[0];
    dz = rs2_data == '0;
    ovf = sgn && rs1_data == {1'b1, {(XLEN-1){1'b0}}} && rs2_data == '1;
    a1 = (sgn && rs1_data[XLEN-1]) ? -rs1_data : rs1_data;
    a2 = (sgn && rs2_data[XLEN-1]) ? -rs2_data : rs2_data;
    // overflow dividend is 0x80000000, which is exactly the DIV overflow result
    spec_res = dz ? (op[1] ? rs1_data : '1) : (op[1] ? '0 : rs1_data);
    accept = state == IDLE && start && !flush;
    last = state == CALC && cnt == ($clog2(DIV_STEPS))'(DIV_STEPS - 1);
    sh = {rem[XLEN-1:0], quo[XLEN-1]};
    ge = sh >= {1'b0, dvs};
    r_n = ge ? sh - {1'b0, dvs} : sh;
    q_n = {quo[XLEN-2:0], ge};
    fin = is_rem ? (neg_r ? -r_n[XLEN-1:0] : r_n[XLEN-1:0]) : (neg_q ? -q_n : q_n);
    state_n = flush ? IDLE
            : accept ? ((dz || ovf) ? DONE : CALC)
            : last ? DONE
            : state == DONE ? IDLE
            : state;
    busy = state != IDLE;
    done = state == DONE && !flush;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      is_rem <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      result <= '0;
    end else if (accept) begin
      cnt <= '0;
      is_rem <= op[1];
      neg_q <= sgn && (rs1_data[XLEN-1] ^ rs2_data[XLEN-1]);
      neg_r <= sgn && rs1_data[XLEN-1];
      rem <= '0;
      quo <= a1;
      dvs <= a2;
      if (dz || ovf) result <= spec_res;
    end else if (state == CALC && !flush) begin
      cnt <= cnt + 1'b1;
      rem <= r_n;
      quo <= q_n;
      if (last) result <= fin;
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized and directed checks of div_unit against an arithmetic reference model
module tb_div_unit;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0;
  logic [1:0] op = 2'b00;
  logic [31:0] rs1_data = '0, rs2_data = '0;
  logic busy, done;
  logic [31:0] result;
  int checks = 0, failures = 0;

  div_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : a;
    case (o)
      2'b00: return $signed(a) / $signed(b);
      2'b01: return a / b;
      2'b10: return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
  endfunction

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; rs1_data = a; rs2_data = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // called at the first negedge after the accepting edge (n=1); returns cycles to done
  task automatic wait_done(output int lat, output logic [31:0] r);
    bit seen = 0;
    lat = 0; r = 'x;
    for (int n = 1; n <= 40 && !seen; n++) begin
      if (n > 1) @(negedge clk);
      if (done) begin seen = 1; lat = n; r = result; end
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int lat;
    logic [31:0] r;
    launch(o, a, b);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(lat, r);
    chk({tag, "_lat"}, 32'(lat), 32'(model_lat(o, a, b)));
    chk({tag, "_res"}, r, model(o, a, b));
    @(negedge clk);
    chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
    chk({tag, "_hold"}, result, model(o, a, b));
  endtask

  initial begin
    int lat, pulses;
    logic [31:0] r, a, b, prev;
    logic [1:0] o;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset", {busy, done, 30'd0} | result, 32'd0);

    run_op("divu_100_7", 2'b01, 32'd100, 32'd7);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7);
    run_op("div_m7_2", 2'b00, -32'sd7, 32'd2);
    run_op("rem_m7_2", 2'b10, -32'sd7, 32'd2);
    run_op("rem_7_m2", 2'b10, 32'd7, -32'sd2);
    run_op("div_5_0", 2'b00, 32'd5, 32'd0);
    run_op("remu_5_0", 2'b11, 32'd5, 32'd0);
    run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_big", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_max", 2'b01, 32'hFFFF_FFFF, 32'd1);

    // flush when the step counter reads 10: no done, result untouched
    prev = result;
    launch(2'b01, 32'd12345, 32'd11);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    chk("flush_done_same_cycle", 32'(done), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_idle", {30'd0, busy, done}, 32'd0);
    chk("flush_result", result, prev);
    pulses = 0;
    repeat (40) begin @(negedge clk); if (done) pulses++; end
    chk("flush_no_pulse", 32'(pulses), 32'd0);
    run_op("after_flush", 2'b00, -32'sd1000, 32'd7);

    // flush together with start in IDLE blocks acceptance
    @(negedge clk);
    op = 2'b01; rs1_data = 32'd9; rs2_data = 32'd3; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start_idle", 32'(busy), 32'd0);

    // start pulsed while busy is ignored
    launch(2'b01, 32'd1000, 32'd9);
    repeat (4) @(negedge clk);
    op = 2'b10; rs1_data = 32'd77; rs2_data = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, r);
    chk("busy_start_res", r, 32'd111);
    chk("busy_start_lat", 32'(lat + 5), 32'd33);

    // reset mid-calculation
    @(negedge clk);
    launch(2'b00, 32'd500, 32'd3);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_calc", {busy, done, 30'd0} | result, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = -32'($urandom_range(1, 100));
        4: a = 32'($urandom_range(0, 50));
        default: ;
      endcase
      run_op("rand", o, a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
